// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect strobe and decode output.
// master = fetch unit side, slave = memory/decode/redirect environment side.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM (REQ/WAIT/HOLD/DROP) feeding one decode slot.
// Redirects win over every other event; a request already in flight is drained in DROP.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus_io
);
   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [1:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [63:0] out_pc_q, out_pc_d;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      if (bus_io.redirect_valid) begin
         // An accepted-but-unanswered request must be drained in DROP before refetching.
         pc_d        = bus_io.redirect_pc & ~64'h3;
         out_valid_d = 1'b0;
         case (state_q)
            S_REQ:   state_d = bus_io.imem_req_ready ? S_DROP : S_REQ;
            S_WAIT:  state_d = bus_io.imem_rsp_valid ? S_REQ : S_DROP;
            S_HOLD:  state_d = S_REQ;
            default: state_d = bus_io.imem_rsp_valid ? S_REQ : S_DROP;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (bus_io.imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (bus_io.imem_rsp_valid) begin
                  out_instr_d = bus_io.imem_rsp_data;
                  out_pc_d    = pc_q;
                  out_valid_d = 1'b1;
                  pc_d        = pc_q + 64'd4;
                  state_d     = S_HOLD;
               end
            end
            S_HOLD: begin
               if (bus_io.out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = S_REQ;
               end
            end
            default: begin
               if (bus_io.imem_rsp_valid) state_d = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= NOP;
         out_pc_q    <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign bus_io.imem_req_valid = (state_q == S_REQ);
   assign bus_io.imem_req_addr  = pc_q;
   assign bus_io.out_valid      = out_valid_q;
   assign bus_io.out_instr      = out_instr_q;
   assign bus_io.out_pc         = out_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory/redirect model pushes expected deliveries,
// an independent monitor pops and compares them at each output handshake.
module tb_fetch_unit;
   localparam logic [63:0] RPC = 64'h1000;

   logic clk, rst;
   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus_io(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;
   bit          pending, tainted, use_fixed;
   int          delay;
   logic [63:0] pc_model, mem_addr;
   logic [31:0] fixed_word;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus followed by the reference-model update for that edge.
   task automatic step(input bit rdy, input bit rd, input logic [63:0] rpc, input bit ordy, input int lat);
      bit          rsp, acc;
      logic [31:0] d;
      logic [63:0] acc_addr;
      @(posedge clk);
      #1;
      rsp = pending && (delay == 0);
      if (pending && delay > 0) delay--;
      d = use_fixed ? fixed_word : $urandom;
      bus.imem_req_ready = rdy;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = d;
      bus.redirect_valid = rd;
      bus.redirect_pc    = rpc;
      bus.out_ready      = ordy;
      @(negedge clk);
      if (bus.imem_req_valid) begin
         chk("req_addr", bus.imem_req_addr, pc_model);
         chk("one_outstanding", {63'd0, pending}, 64'd0);
      end
      acc      = bus.imem_req_valid && rdy;
      acc_addr = pc_model;
      if (rsp) begin
         pending = 1'b0;
         if (!rd && !tainted) begin
            expq.push_back('{mem_addr, d});
            pc_model = mem_addr + 64'd4;
         end
      end
      if (rd) begin
         pc_model = {rpc[63:2], 2'b00};
         if (pending) tainted = 1'b1;
      end
      if (acc) begin
         pending  = 1'b1;
         tainted  = rd;
         delay    = lat;
         mem_addr = acc_addr;
      end
   endtask

   task automatic settle();
      repeat (4) step(1'b0, 1'b0, 64'd0, 1'b1, 0);
   endtask

   task automatic do_reset();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'd0;
      bus.out_ready      = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_out_instr", {32'd0, bus.out_instr}, 64'h13);
      chk("rst_out_pc", bus.out_pc, RPC);
      chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
      chk("rst_req_addr", bus.imem_req_addr, RPC);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      expq.delete();
      pending  = 1'b0;
      tainted  = 1'b0;
      delay    = 0;
      pc_model = RPC;
   endtask

   // Monitor: stability in hold, redirect kills output, in-order delivery.
   initial begin
      bit          p_ov, p_or, p_rd;
      logic [31:0] p_instr;
      logic [63:0] p_pc;
      exp_t        e;
      p_ov = 0; p_or = 0; p_rd = 0; p_instr = '0; p_pc = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_ov = 0; p_or = 0; p_rd = 0;
         end else begin
            if (p_rd)
               chk("ov_after_redirect", {63'd0, bus.out_valid}, 64'd0);
            else if (p_ov && !p_or) begin
               chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
               chk("hold_instr", {32'd0, bus.out_instr}, {32'd0, p_instr});
               chk("hold_pc", bus.out_pc, p_pc);
            end
            if (bus.out_valid) begin
               chk("no_req_while_out", {63'd0, bus.imem_req_valid}, 64'd0);
               chk("out_expected", {63'd0, (expq.size() != 0)}, 64'd1);
               if (expq.size() != 0 && (bus.out_ready || bus.redirect_valid)) begin
                  e = expq.pop_front();
                  pops++;
                  chk("out_pc", bus.out_pc, e.pc);
                  chk("out_instr", {32'd0, bus.out_instr}, {32'd0, e.instr});
               end
            end
            p_ov = bus.out_valid; p_or = bus.out_ready; p_rd = bus.redirect_valid;
            p_instr = bus.out_instr; p_pc = bus.out_pc;
         end
      end
   end

   initial begin
      int pops0;
      use_fixed  = 1'b1;
      fixed_word = 32'h0050_0093;
      do_reset();

      // Minimum-latency fetch and sequential next address
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("lat_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("lat_out_pc", bus.out_pc, 64'h1000);
      chk("lat_out_instr", {32'd0, bus.out_instr}, 64'h0050_0093);
      step(1, 0, 0, 1, 0);
      chk("next_addr", bus.imem_req_addr, 64'h1004);

      // Decode back-pressure for five cycles
      settle();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      repeat (5) begin
         step(0, 0, 0, 0, 0);
         chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("bp_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
      end
      settle();

      // Redirect while waiting, late response dropped
      step(1, 0, 0, 0, 3);
      step(0, 1, 64'h2002, 0, 0);
      repeat (3) begin
         step(0, 0, 0, 0, 0);
         chk("drop_no_out", {63'd0, bus.out_valid}, 64'd0);
      end
      step(1, 0, 0, 0, 0);
      chk("redir_addr", bus.imem_req_addr, 64'h2000);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("redir_out_pc", bus.out_pc, 64'h2000);
      settle();

      // Redirect coincident with response
      step(1, 0, 0, 0, 0);
      step(0, 1, 64'h3000, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("coinc_no_out", {63'd0, bus.out_valid}, 64'd0);
      chk("coinc_addr", bus.imem_req_addr, 64'h3000);
      settle();

      // PC wrap at top of address space
      step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("wrap_addr", bus.imem_req_addr, 64'h0);
      settle();

      // Asynchronous reset while holding an instruction
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
      #2;
      do_reset();
      step(1, 0, 0, 0, 0);
      chk("post_rst_addr", bus.imem_req_addr, RPC);

      // Randomized traffic
      use_fixed = 1'b0;
      pops0 = pops;
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), rpc,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3));
      end
      chk("rand_deliveries", {63'd0, (pops > pops0 + 50)}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
